// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: default widths, start PC,
// the 2-bit sequencer state encoding and a saturating counter helper.
package fetch_sequencer_pkg;

  localparam int unsigned PC_W_DEF     = 10;
  localparam int unsigned INSTR_W_DEF  = 9;
  localparam int unsigned START_PC_DEF = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == '1) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory req/ack bus between the fetch sequencer (master)
// and instruction memory (slave).
interface fetch_sequencer_if
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
);

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );

endinterface

// File: rtl/fetch_sequencer_pc_next_sel.sv
// Combinational next-PC selection for an accepted instruction.
// Priority: halt (hold pc) > jump (target) > taken branch (target) > pc+1.
module pc_next_sel
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
) (
  input  logic            halt,
  input  logic            jump,
  input  logic            branch,
  input  logic            cond,
  input  logic [PC_W-1:0] target,
  input  logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] next_pc,
  output logic            go_halt
);

  // Resolve simultaneous strobes by fixed priority; pc+1 wraps naturally.
  always_comb begin
    go_halt = 1'b0;
    next_pc = pc + PC_W'(1);
    if (halt) begin
      go_halt = 1'b1;
      next_pc = pc;
    end else if (jump) begin
      next_pc = target;
    end else if (branch && cond) begin
      next_pc = target;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, fetches one instruction at a time over the
// imem req/ack bus, presents it to decode and picks the next PC from the
// decoded halt/jump/branch strobes.
// Optional: define FETCH_PERF_CNT_EN to add saturating instr_count and
// stall_count outputs.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEF,
  parameter int unsigned     INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] START_PC = PC_W'(START_PC_DEF)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  fetch_sequencer_if.master  imem,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch,
  input  logic               jump,
  input  logic               halt,
  input  logic               cond,
  input  logic [PC_W-1:0]    target,
  output logic [PC_W-1:0]    pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]        instr_count,
  output logic [15:0]        stall_count,
`endif
  output logic               done
);

  fetch_state_e       state, state_nxt;
  logic [PC_W-1:0]    pc_q, pc_nxt, sel_pc;
  logic [INSTR_W-1:0] instr_q, instr_nxt;
  logic               go_halt;
  logic               accept;
  logic               restart;

  assign accept  = (state == ST_ISSUE) && instr_ready;
  assign restart = start && ((state == ST_IDLE) || (state == ST_HALTED));

  pc_next_sel #(
    .PC_W (PC_W)
  ) u_pc_next_sel (
    .halt    (halt),
    .jump    (jump),
    .branch  (branch),
    .cond    (cond),
    .target  (target),
    .pc      (pc_q),
    .next_pc (sel_pc),
    .go_halt (go_halt)
  );

  // Next-state, next-PC and instruction capture.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    instr_nxt = instr_q;
    case (state)
      ST_IDLE, ST_HALTED: begin
        if (restart) begin
          state_nxt = ST_FETCH;
          pc_nxt    = START_PC;
        end
      end
      ST_FETCH: begin
        if (imem.imem_ack) begin
          instr_nxt = imem.imem_rdata;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (accept) begin
          pc_nxt    = sel_pc;
          state_nxt = go_halt ? ST_HALTED : ST_FETCH;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, PC and instruction registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      pc_q    <= START_PC;
      instr_q <= '0;
    end else begin
      state   <= state_nxt;
      pc_q    <= pc_nxt;
      instr_q <= instr_nxt;
    end
  end

  // Outputs decode straight from state so an async reset drops imem_req at once.
  assign imem.imem_req  = (state == ST_FETCH);
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = (state == ST_ISSUE);
  assign pc             = pc_q;
  assign done           = (state == ST_HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic stall;
  assign stall = ((state == ST_FETCH) && !imem.imem_ack) ||
                 ((state == ST_ISSUE) && !instr_ready);

  // Saturating accepted-instruction and stall-cycle counters, cleared on start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_count <= '0;
      stall_count <= '0;
    end else if (restart) begin
      instr_count <= '0;
      stall_count <= '0;
    end else begin
      if (accept) instr_count <= sat_inc16(instr_count);
      if (stall)  stall_count <= sat_inc16(stall_count);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed latency/handshake
// sequences, a table of next-PC vectors, a small PC_W=4 instance for wrap,
// and a randomized run against a transaction-level program-flow model.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, start, ack, ready, branch, jump, halt, cond;
  logic [9:0] target;
  logic [8:0] instr;
  logic       instr_valid, done;
  logic [9:0] pc;
  logic [8:0] mem [1024];

  int n_checks = 0;
  int n_fail   = 0;

  fetch_sequencer_if #(.PC_W(10), .INSTR_W(9)) bus ();
  assign bus.imem_ack   = ack;
  assign bus.imem_rdata = mem[bus.imem_addr];

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] instr_count, stall_count, s_ic, s_sc;
`endif

  fetch_sequencer #(.PC_W(10), .INSTR_W(9), .START_PC(10'd0)) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .imem        (bus),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (ready),
    .branch      (branch),
    .jump        (jump),
    .halt        (halt),
    .cond        (cond),
    .target      (target),
    .pc          (pc),
`ifdef FETCH_PERF_CNT_EN
    .instr_count (instr_count),
    .stall_count (stall_count),
`endif
    .done        (done)
  );

  // Small instance: zero-wait memory, always ready, no strobes -> pure sequential run.
  fetch_sequencer_if #(.PC_W(4), .INSTR_W(9)) sbus ();
  assign sbus.imem_ack   = sbus.imem_req;
  assign sbus.imem_rdata = '0;
  logic [8:0] s_instr;
  logic       s_valid, s_done;
  logic [3:0] s_pc;

  fetch_sequencer #(.PC_W(4), .INSTR_W(9), .START_PC(4'd0)) u_small (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .imem        (sbus),
    .instr       (s_instr),
    .instr_valid (s_valid),
    .instr_ready (1'b1),
    .branch      (1'b0),
    .jump        (1'b0),
    .halt        (1'b0),
    .cond        (1'b0),
    .target      (4'd0),
    .pc          (s_pc),
`ifdef FETCH_PERF_CNT_EN
    .instr_count (s_ic),
    .stall_count (s_sc),
`endif
    .done        (s_done)
  );

  int unsigned s_addrs[$];
  always @(posedge clk)
    if (reset_n && sbus.imem_req && sbus.imem_ack) s_addrs.push_back(32'(sbus.imem_addr));

  typedef struct {
    logic [9:0] pc_at;
    logic       b, j, h, c;
    logic [9:0] tgt;
    logic       exp_halt;
    logic [9:0] exp_addr;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] m_pc;
  logic [8:0] m_instr;
  logic       m_halted, was_halted;

  initial begin
    reset_n = 1'b0; start = 1'b0; ack = 1'b0; ready = 1'b0;
    branch = 1'b0; jump = 1'b0; halt = 1'b0; cond = 1'b0; target = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 9'($urandom);

    vecs[0] = '{pc_at: 10'd7,    b: 1, j: 0, h: 0, c: 1, tgt: 10'd40,  exp_halt: 0, exp_addr: 10'd40};
    vecs[1] = '{pc_at: 10'd7,    b: 1, j: 0, h: 0, c: 0, tgt: 10'd40,  exp_halt: 0, exp_addr: 10'd8};
    vecs[2] = '{pc_at: 10'd7,    b: 0, j: 0, h: 0, c: 1, tgt: 10'd40,  exp_halt: 0, exp_addr: 10'd8};
    vecs[3] = '{pc_at: 10'd12,   b: 0, j: 1, h: 1, c: 0, tgt: 10'd100, exp_halt: 1, exp_addr: 10'd12};
    vecs[4] = '{pc_at: 10'd300,  b: 1, j: 1, h: 0, c: 0, tgt: 10'd555, exp_halt: 0, exp_addr: 10'd555};
    vecs[5] = '{pc_at: 10'd20,   b: 1, j: 0, h: 1, c: 1, tgt: 10'd5,   exp_halt: 1, exp_addr: 10'd20};
    vecs[6] = '{pc_at: 10'd1023, b: 0, j: 0, h: 0, c: 0, tgt: 10'd77,  exp_halt: 0, exp_addr: 10'd0};
    vecs[7] = '{pc_at: 10'd64,   b: 0, j: 1, h: 0, c: 0, tgt: 10'd900, exp_halt: 0, exp_addr: 10'd900};

    // Reset state, then idle with a stray ack.
    tick(); tick();
    check("rst_req",   32'(bus.imem_req), 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_done",  32'(done), 0);
    check("rst_pc",    32'(pc), 0);
    check("rst_instr", 32'(instr), 0);
    #2 reset_n = 1'b1;
    ack = 1'b1;
    tick();
    check("idle_req",   32'(bus.imem_req), 0);
    check("idle_valid", 32'(instr_valid), 0);

    // Zero-wait run: one instruction per two cycles at 0,1,2,3.
    ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("seq_req",  32'(bus.imem_req), 1);
      check("seq_addr", 32'(bus.imem_addr), 32'(k));
      tick();
      check("seq_valid", 32'(instr_valid), 1);
      check("seq_noreq", 32'(bus.imem_req), 0);
      check("seq_instr", 32'(instr), 32'(mem[k]));
      tick();
    end

    // Ack delayed 3 cycles at pc=5.
    check("pre5_addr", 32'(bus.imem_addr), 4);
    tick();
    ack = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      check("wait_req",   32'(bus.imem_req), 1);
      check("wait_addr",  32'(bus.imem_addr), 5);
      check("wait_valid", 32'(instr_valid), 0);
      tick();
    end
    check("wait_req",  32'(bus.imem_req), 1);
    check("wait_addr", 32'(bus.imem_addr), 5);
    ack = 1'b1; ready = 1'b0;
    tick();
    ack = 1'b0;
    check("ack_valid", 32'(instr_valid), 1);
    check("ack_instr", 32'(instr), 32'(mem[5]));
`ifdef FETCH_PERF_CNT_EN
    check("perf_instr", 32'(instr_count), 5);
    check("perf_stall", 32'(stall_count), 3);
`endif

    // Decode stalled 5 cycles with strobes present: everything holds.
    halt = 1'b1; jump = 1'b1; target = 10'd99;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("stall_valid", 32'(instr_valid), 1);
      check("stall_instr", 32'(instr), 32'(mem[5]));
      check("stall_pc",    32'(pc), 5);
      check("stall_done",  32'(done), 0);
    end
    halt = 1'b0; jump = 1'b0; ready = 1'b1;
    tick();
    check("post_stall_addr", 32'(bus.imem_addr), 6);

    // Table of next-PC decisions.
    foreach (vecs[i]) begin
      if (done) begin
        start = 1'b1; tick(); start = 1'b0;
        check("restart_req",  32'(bus.imem_req), 1);
        check("restart_addr", 32'(bus.imem_addr), 0);
      end
      ack = 1'b1; ready = 1'b1;
      tick();
      jump = 1'b1; target = vecs[i].pc_at;
      tick();
      jump = 1'b0;
      check("vec_setup_addr", 32'(bus.imem_addr), 32'(vecs[i].pc_at));
      tick();
      check("vec_valid", 32'(instr_valid), 1);
      branch = vecs[i].b; jump = vecs[i].j; halt = vecs[i].h;
      cond = vecs[i].c; target = vecs[i].tgt;
      tick();
      branch = 1'b0; jump = 1'b0; halt = 1'b0; cond = 1'b0;
      if (vecs[i].exp_halt) begin
        check("vec_done",    32'(done), 1);
        check("vec_hlt_req", 32'(bus.imem_req), 0);
        check("vec_hlt_pc",  32'(pc), 32'(vecs[i].pc_at));
        jump = 1'b1; halt = 1'b1; target = 10'd3;
        tick(); tick();
        jump = 1'b0; halt = 1'b0;
        check("vec_hold_req",  32'(bus.imem_req), 0);
        check("vec_hold_done", 32'(done), 1);
        check("vec_hold_pc",   32'(pc), 32'(vecs[i].pc_at));
      end else begin
        check("vec_done", 32'(done), 0);
        check("vec_req",  32'(bus.imem_req), 1);
        check("vec_addr", 32'(bus.imem_addr), 32'(vecs[i].exp_addr));
      end
    end

    // Randomized program flow against the model.
    m_pc = vecs[7].exp_addr;
    m_instr = '0;
    m_halted = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      was_halted = m_halted;
      check("rnd_done", 32'(done), 32'(was_halted));
      if (was_halted) check("rnd_halt_req", 32'(bus.imem_req), 0);
      ack    = ($urandom_range(0, 1) == 1);
      ready  = ($urandom_range(0, 2) != 0);
      halt   = ($urandom_range(0, 15) == 0);
      jump   = ($urandom_range(0, 7) == 0);
      branch = ($urandom_range(0, 3) == 0);
      cond   = ($urandom_range(0, 1) == 1);
      target = 10'($urandom);
      start  = ($urandom_range(0, 5) == 0);
      if (bus.imem_req && ack) begin
        check("rnd_fetch_addr", 32'(bus.imem_addr), 32'(m_pc));
        m_instr = mem[m_pc];
      end
      if (instr_valid && ready) begin
        check("rnd_instr", 32'(instr), 32'(m_instr));
        check("rnd_pc",    32'(pc), 32'(m_pc));
        if (halt)                m_halted = 1'b1;
        else if (jump)           m_pc = target;
        else if (branch && cond) m_pc = target;
        else                     m_pc = m_pc + 10'd1;
      end
      if (was_halted && start) begin
        m_halted = 1'b0;
        m_pc = 10'd0;
      end
      tick();
    end
    start = 1'b0; halt = 1'b0; jump = 1'b0; branch = 1'b0; cond = 1'b0;

    // Small instance wrapped 15 -> 0 with no gaps.
    check("wrap_count", 32'(s_addrs.size() >= 20), 1);
    for (int i = 0; i < 20 && i < s_addrs.size(); i++)
      check("wrap_addr", s_addrs[i], 32'(i % 16));

    // Async reset in the middle of a fetch.
    ack = 1'b0; ready = 1'b1;
    start = done;
    tick();
    start = 1'b0;
    tick();
    check("mid_req_before", 32'(bus.imem_req), 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_req_dropped", 32'(bus.imem_req), 0);
    check("mid_valid",       32'(instr_valid), 0);
    check("mid_pc",          32'(pc), 0);
    ack = 1'b1;
    #3 reset_n = 1'b1;
    tick();
    check("post_rst_req", 32'(bus.imem_req), 0);
    check("post_rst_done", 32'(done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
